acq_capture_ctrl: RTL and testbench

Pre/post-trigger capture controller for the 10-bit, 100 MSPS acquisition path. Takes the raw ADC sample stream and drives the write port of the 2048×10 sample buffer (address, write enable, data). Runs a circular pre-trigger fill and detects a rising level-crossing trigger. Then writes a fixed post-trigger count and freezes, reporting where the record starts so the readout side can unroll it.

---
 rtl/acq_capture_ctrl_if.sv | 13 +
 rtl/acq_capture_ctrl.sv | 147 ++++++++++++++
 tb/tb_acq_capture_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/acq_capture_ctrl_if.sv
// Write port of the capture sample buffer: address, data and write enable.
// The capture controller drives the master side; the buffer sits on the slave side.
interface acq_capture_ctrl_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 10
);
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          we;

    modport master (output addr, output din, output we);
    modport slave  (input  addr, input  din, input  we);
endinterface

// File: rtl/acq_capture_ctrl.sv
// Pre/post-trigger capture controller: circular pre-fill, rising level-crossing trigger, fixed post count.
// Optional ACQ_EXT_TRIG_EN adds i_ext_trig, ORed into the trigger while ARMED.
module acq_capture_ctrl #(
    parameter int unsigned AW        = 11,
    parameter int unsigned DW        = 10,
    parameter int unsigned PRE_DEPTH = 512
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [DW-1:0]       i_adc_data,
    input  logic [DW-1:0]       i_trig_level,
    input  logic                i_arm,
    input  logic                i_abort,
`ifdef ACQ_EXT_TRIG_EN
    input  logic                i_ext_trig,
`endif
    acq_capture_ctrl_if.master  m_sram,
    output logic                o_busy,
    output logic                o_done,
    output logic [AW-1:0]       o_trig_addr,
    output logic [AW-1:0]       o_rec_start
);

    localparam int unsigned   POST_DEPTH = (2 ** AW) - PRE_DEPTH;
    localparam logic [AW-1:0] PreLast    = AW'(PRE_DEPTH - 1);
    localparam logic [AW-1:0] PostLast   = AW'(POST_DEPTH - 1);
    localparam logic [AW-1:0] PreOff     = AW'(PRE_DEPTH);

    typedef enum logic [2:0] {StIdle, StPre, StArmed, StPost, StDone} state_e;

    state_e        r_state,     w_state_next;
    logic [AW-1:0] r_wptr,      w_wptr_next;
    logic [AW-1:0] r_cnt,       w_cnt_next;
    logic [AW-1:0] r_addr,      w_addr_next;
    logic [DW-1:0] r_din,       w_din_next;
    logic          r_we,        w_we_next;
    logic          r_busy,      w_busy_next;
    logic          r_done,      w_done_next;
    logic [AW-1:0] r_trig_addr, w_trig_addr_next;
    logic [AW-1:0] r_rec_start, w_rec_start_next;
    logic          w_write;
    logic          w_trig;

    // r_din still holds the previously written sample, i.e. the "previous" side of the crossing.
`ifdef ACQ_EXT_TRIG_EN
    assign w_trig = ((r_din < i_trig_level) && (i_adc_data >= i_trig_level)) || i_ext_trig;
`else
    assign w_trig = (r_din < i_trig_level) && (i_adc_data >= i_trig_level);
`endif

    always_comb begin
        w_state_next     = r_state;
        w_wptr_next      = r_wptr;
        w_cnt_next       = r_cnt;
        w_addr_next      = r_addr;
        w_din_next       = r_din;
        w_we_next        = 1'b0;
        w_trig_addr_next = r_trig_addr;
        w_rec_start_next = r_rec_start;
        w_write          = 1'b0;

        if (i_abort) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (i_arm) begin
                        w_state_next = StPre;
                        w_wptr_next  = '0;
                        w_cnt_next   = '0;
                    end
                end
                StPre: begin
                    w_write    = 1'b1;
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == PreLast) begin
                        w_state_next = StArmed;
                        w_cnt_next   = '0;
                    end
                end
                StArmed: begin
                    w_write = 1'b1;
                    if (w_trig) begin
                        w_trig_addr_next = r_wptr;
                        w_rec_start_next = r_wptr - PreOff;
                        w_cnt_next       = AW'(1);
                        w_state_next     = (POST_DEPTH == 1) ? StDone : StPost;
                    end
                end
                StPost: begin
                    w_write    = 1'b1;
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == PostLast) begin
                        w_state_next = StDone;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end

        if (w_write) begin
            w_addr_next = r_wptr;
            w_din_next  = i_adc_data;
            w_we_next   = 1'b1;
            w_wptr_next = r_wptr + 1'b1;
        end

        w_busy_next = (w_state_next == StPre) || (w_state_next == StArmed) ||
                      (w_state_next == StPost);
        w_done_next = (w_state_next == StDone);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_wptr      <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_din       <= '0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_trig_addr <= '0;
            r_rec_start <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wptr      <= w_wptr_next;
            r_cnt       <= w_cnt_next;
            r_addr      <= w_addr_next;
            r_din       <= w_din_next;
            r_we        <= w_we_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_trig_addr <= w_trig_addr_next;
            r_rec_start <= w_rec_start_next;
        end
    end

    assign m_sram.addr = r_addr;
    assign m_sram.din  = r_din;
    assign m_sram.we   = r_we;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_trig_addr = r_trig_addr;
    assign o_rec_start = r_rec_start;

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// Self-checking bench for acq_capture_ctrl: directed and random captures against a sample-index model.
// Define ACQ_EXT_TRIG_EN on both RTL and bench to exercise the external trigger.
module tb_acq_capture_ctrl;

    localparam int AW    = 11;
    localparam int DW    = 10;
    localparam int PRE   = 512;
    localparam int DEPTH = 2 ** AW;
    localparam int POST  = DEPTH - PRE;
    localparam int MAXS  = 8192;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] adc;
    logic [DW-1:0] trig_level;
    logic          arm;
    logic          abort;
    logic          ext;
    logic          busy;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] rec_start;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int last_trig = 0;

    logic [DW-1:0] stim     [MAXS];
    bit            ext_stim [MAXS];
    logic [DW-1:0] mem      [DEPTH];

    acq_capture_ctrl_if #(.AW(AW), .DW(DW)) sram_bus ();

    acq_capture_ctrl #(.AW(AW), .DW(DW), .PRE_DEPTH(PRE)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_adc_data   (adc),
        .i_trig_level (trig_level),
        .i_arm        (arm),
        .i_abort      (abort),
`ifdef ACQ_EXT_TRIG_EN
        .i_ext_trig   (ext),
`endif
        .m_sram       (sram_bus.master),
        .o_busy       (busy),
        .o_done       (done),
        .o_trig_addr  (trig_addr),
        .o_rec_start  (rec_start)
    );

    always #5 clk = ~clk;

    // Behaves as the sample buffer: stores on the edge after the write port is presented.
    always @(posedge clk) begin
        if (sram_bus.we === 1'b1) begin
            mem[sram_bus.addr] <= sram_bus.din;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        for (int k = 0; k < MAXS; k++) begin
            stim[k]     = '0;
            ext_stim[k] = 1'b0;
        end
    endtask

    // Sample k after arm lands at address k mod DEPTH; the trigger is the first sample index
    // at or beyond PRE that crosses the level upward (or carries ext_trig).
    task automatic run_capture(input string tag, input int lvl, input int arm_at,
                               input int stop_at);
        int t, e, bad, miss, exp_trig, exp_rec;
        t = -1;
        for (int k = PRE; k < MAXS; k++) begin
            if (t < 0 && (((int'(stim[k-1]) < lvl) && (int'(stim[k]) >= lvl)) || ext_stim[k]))
                t = k;
        end
        exp_trig = t % DEPTH;
        exp_rec  = (t - PRE) % DEPTH;
        e        = t + POST - 1;
        bad      = 0;

        @(negedge clk);
        trig_level = DW'(lvl);
        arm        = 1'b1;
        for (int k = 0; k <= e; k++) begin
            @(negedge clk);
            arm = (k == arm_at);
            adc = stim[k];
            ext = ext_stim[k];
            @(posedge clk);
            #1;
            if (sram_bus.we !== 1'b1 || sram_bus.addr !== AW'(k % DEPTH) ||
                sram_bus.din !== stim[k] || busy !== (k != e) || done !== (k == e))
                bad++;
            if (k == stop_at) begin
                check({tag, "_partial_stream"}, bad, 0);
                arm = 1'b0;
                ext = 1'b0;
                return;
            end
        end
        check({tag, "_stream"}, bad, 0);

        @(negedge clk);
        arm = 1'b0;
        ext = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_tail_we"}, 32'(sram_bus.we), 0);
        check({tag, "_tail_done"}, 32'(done), 1);
        check({tag, "_trig_addr"}, 32'(trig_addr), exp_trig);
        check({tag, "_rec_start"}, 32'(rec_start), exp_rec);

        miss = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[(exp_rec + i) % DEPTH] !== stim[t - PRE + i]) miss++;
        end
        check({tag, "_record"}, miss, 0);
        last_trig = exp_trig;
    endtask

    initial begin
        int wc0;
        rst        = 1'b0;
        arm        = 1'b0;
        abort      = 1'b0;
        adc        = '0;
        trig_level = '0;
        ext        = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_we",    32'(sram_bus.we),   0);
        check("rst_addr",  32'(sram_bus.addr), 0);
        check("rst_din",   32'(sram_bus.din),  0);
        check("rst_busy",  32'(busy),          0);
        check("rst_done",  32'(done),          0);
        check("rst_trig",  32'(trig_addr),     0);
        check("rst_rec",   32'(rec_start),     0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Ramp: trigger at value 600.
        clear_stim();
        for (int k = 0; k < MAXS; k++) stim[k] = DW'(k % 1024);
        run_capture("ramp", 600, -1, -1);

        // Reset in the middle of POST, then a fresh capture must start at address 0.
        run_capture("ramp_cut", 600, -1, 700);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_we",   32'(sram_bus.we),   0);
        check("midrst_addr", 32'(sram_bus.addr), 0);
        check("midrst_busy", 32'(busy),          0);
        check("midrst_trig", 32'(trig_addr),     0);
        @(posedge clk);
        #1;
        check("midrst_hold_we", 32'(sram_bus.we), 0);
        @(negedge clk);
        rst = 1'b0;
        run_capture("ramp_again", 600, -1, -1);

        // Long ARMED dwell wraps the write pointer.
        clear_stim();
        for (int k = 0; k < MAXS; k++) stim[k] = (k < PRE + 3000) ? DW'(100) : DW'(700);
        run_capture("wrap", 600, -1, -1);
        check("wrap_trig_const", 32'(trig_addr), (3000 + 512) % 2048);

        // Crossing inside PRE is ignored; arm pulsed in POST is ignored.
        clear_stim();
        for (int k = 0; k < MAXS; k++)
            stim[k] = (k < 200) ? DW'(300) : (k < 800) ? DW'(700) : (k < 900) ? DW'(300) : DW'(700);
        run_capture("precross", 600, 1000, -1);
        check("precross_trig_const", 32'(trig_addr), 900);

        // arm together with abort from DONE: back to IDLE, no writes, trigger address held.
        @(negedge clk);
        arm   = 1'b1;
        abort = 1'b1;
        wc0   = wr_cnt;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        @(negedge clk);
        arm   = 1'b0;
        abort = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_nowrite", wr_cnt - wc0, 0);
        check("abort_trig_hold", 32'(trig_addr), last_trig);

        // Random data and thresholds; a forced crossing guarantees a trigger exists.
        for (int r = 0; r < 3; r++) begin
            clear_stim();
            for (int k = 0; k < MAXS; k++) stim[k] = DW'($urandom_range(0, 1023));
            stim[4000] = '0;
            stim[4001] = DW'(1023);
            run_capture($sformatf("rand%0d", r), int'($urandom_range(100, 900)), -1, -1);
        end

`ifdef ACQ_EXT_TRIG_EN
        clear_stim();
        ext_stim[1000] = 1'b1;
        run_capture("ext", 600, -1, -1);
        check("ext_trig_const", 32'(trig_addr), 1000);
        check("ext_rec_const",  32'(rec_start), 488);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
